// File: rtl/bit_selection_ram_port_pkg.sv
// Shared width codes and lane tables for the RAM port bit selection/deselection logic.
// Bits 4, 9, 14 and 19 of each 5-bit group are parity-style spares, so they are not used in 1- and 2-bit modes.
package bit_selection_ram_port_pkg;

  localparam logic [2:0] CONFIG_1BIT  = 3'd1;
  localparam logic [2:0] CONFIG_2BIT  = 3'd2;
  localparam logic [2:0] CONFIG_5BIT  = 3'd3;
  localparam logic [2:0] CONFIG_10BIT = 3'd4;
  localparam logic [2:0] CONFIG_20BIT = 3'd5;
  localparam logic [2:0] CONFIG_40BIT = 3'd6;
  localparam logic [2:0] CONFIG_80BIT = 3'd7;

  // Physical bit for each 1-bit lane, indexed by addr[4:1].
  localparam logic [15:0][4:0] ONE_BIT_POS = {
    5'd18, 5'd17, 5'd16, 5'd15, 5'd13, 5'd12, 5'd11, 5'd10,
    5'd8,  5'd7,  5'd6,  5'd5,  5'd3,  5'd2,  5'd1,  5'd0
  };

  localparam logic [7:0][4:0] TWO_BIT_BASE = {
    5'd17, 5'd15, 5'd12, 5'd10, 5'd7, 5'd5, 5'd2, 5'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WT    = 2'd2
  } state_e;

endpackage

// File: rtl/bit_selection_ram_port_mux.sv
// Combinational placement of a right-aligned write word and its bit mask onto the 20-bit RAM lane.
// Write-side mirror of bit_deselection_mux.
module bit_selection_mux
  import bit_selection_ram_port_pkg::*;
(
  input  logic [2:0]  input_config,
  input  logic [3:0]  lane_sel,
  input  logic [19:0] wrdata,
  input  logic [19:0] bwe,
  output logic [19:0] lane_data,
  output logic [19:0] lane_bwe
);

  logic [4:0] five_base;

  assign five_base = {3'b000, lane_sel[3:2]} * 5'd5;

  always_comb begin
    lane_data = '0;
    lane_bwe  = '0;
    case (input_config)
      CONFIG_1BIT: begin
        lane_data[ONE_BIT_POS[lane_sel]] = wrdata[0];
        lane_bwe[ONE_BIT_POS[lane_sel]]  = bwe[0];
      end
      CONFIG_2BIT: begin
        lane_data[TWO_BIT_BASE[lane_sel[3:1]] +: 2] = wrdata[1:0];
        lane_bwe[TWO_BIT_BASE[lane_sel[3:1]] +: 2]  = bwe[1:0];
      end
      CONFIG_5BIT: begin
        lane_data[five_base +: 5] = wrdata[4:0];
        lane_bwe[five_base +: 5]  = bwe[4:0];
      end
      CONFIG_10BIT: begin
        lane_data = lane_sel[3] ? {wrdata[9:0], 10'b0} : {10'b0, wrdata[9:0]};
        lane_bwe  = lane_sel[3] ? {bwe[9:0], 10'b0}    : {10'b0, bwe[9:0]};
      end
      CONFIG_20BIT, CONFIG_40BIT, CONFIG_80BIT: begin
        lane_data = wrdata;
        lane_bwe  = bwe;
      end
      // Undefined codes leave the mask empty so the strobe writes nothing.
      default: ;
    endcase
  end

endmodule

// File: rtl/bit_selection_ram_port.sv
// Registered RAM write port: lane-aligns each write and optionally follows it with a
// one-cycle readback to the same address; a one-entry skid holds a write arriving meanwhile.
module bit_selection_ram_port
  import bit_selection_ram_port_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  input_config_i,
  input  logic        we_i,
  input  logic        wt_i,
  input  logic [15:0] addr_i,
  input  logic [19:0] wrdata_i,
  input  logic [19:0] bwe_i,
  output logic        busy_o,
  output logic        we_o,
  output logic        re_o,
  output logic [15:0] addr_o,
  output logic [19:0] wrdata_o,
  output logic [19:0] bwe_o
);

  logic [19:0] lane_data, lane_bwe;

  state_e      state_q, state_d;
  logic        we_q, we_d, re_q, re_d, busy_q, busy_d;
  logic [15:0] addr_q, addr_d;
  logic [19:0] wrdata_q, wrdata_d, bwe_q, bwe_d;
  logic        skid_valid_q, skid_valid_d, skid_wt_q, skid_wt_d;
  logic [15:0] skid_addr_q, skid_addr_d;
  logic [19:0] skid_data_q, skid_data_d, skid_bwe_q, skid_bwe_d;

  bit_selection_mux u_mux (
    .input_config (input_config_i),
    .lane_sel     (addr_i[4:1]),
    .wrdata       (wrdata_i),
    .bwe          (bwe_i),
    .lane_data    (lane_data),
    .lane_bwe     (lane_bwe)
  );

  // The state names the cycle currently shown on the outputs; the skid stores already lane-mapped data.
  always_comb begin
    state_d      = state_q;
    we_d         = 1'b0;
    re_d         = 1'b0;
    busy_d       = 1'b0;
    addr_d       = addr_q;
    wrdata_d     = '0;
    bwe_d        = '0;
    skid_valid_d = skid_valid_q;
    skid_wt_d    = skid_wt_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    skid_bwe_d   = skid_bwe_q;
    case (state_q)
      ST_WRITE: begin
        state_d = ST_WT;
        re_d    = 1'b1;
        busy_d  = 1'b1;
        if (we_i) begin
          skid_valid_d = 1'b1;
          skid_wt_d    = wt_i;
          skid_addr_d  = addr_i;
          skid_data_d  = lane_data;
          skid_bwe_d   = lane_bwe;
        end
      end
      ST_WT: begin
        state_d = ST_IDLE;
        if (skid_valid_q) begin
          skid_valid_d = 1'b0;
          we_d         = 1'b1;
          addr_d       = skid_addr_q;
          wrdata_d     = skid_data_q;
          bwe_d        = skid_bwe_q;
          state_d      = skid_wt_q ? ST_WRITE : ST_IDLE;
        end
      end
      default: begin
        if (we_i) begin
          we_d     = 1'b1;
          addr_d   = addr_i;
          wrdata_d = lane_data;
          bwe_d    = lane_bwe;
          state_d  = wt_i ? ST_WRITE : ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      wrdata_q     <= '0;
      bwe_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_wt_q    <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      skid_bwe_q   <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      re_q         <= re_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      wrdata_q     <= wrdata_d;
      bwe_q        <= bwe_d;
      skid_valid_q <= skid_valid_d;
      skid_wt_q    <= skid_wt_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
      skid_bwe_q   <= skid_bwe_d;
    end
  end

  assign we_o     = we_q;
  assign re_o     = re_q;
  assign busy_o   = busy_q;
  assign addr_o   = addr_q;
  assign wrdata_o = wrdata_q;
  assign bwe_o    = bwe_q;

endmodule

// File: tb/tb_bit_selection_ram_port.sv
// Scoreboard bench for bit_selection_ram_port: the driver schedules expected output cycles,
// the monitor pops and compares them whenever the port strobes the RAM.
module tb_bit_selection_ram_port;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [2:0]  input_config_i;
  logic        we_i, wt_i;
  logic [15:0] addr_i;
  logic [19:0] wrdata_i, bwe_i;
  logic        busy_o, we_o, re_o;
  logic [15:0] addr_o;
  logic [19:0] wrdata_o, bwe_o;

  bit_selection_ram_port dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .input_config_i (input_config_i),
    .we_i           (we_i),
    .wt_i           (wt_i),
    .addr_i         (addr_i),
    .wrdata_i       (wrdata_i),
    .bwe_i          (bwe_i),
    .busy_o         (busy_o),
    .we_o           (we_o),
    .re_o           (re_o),
    .addr_o         (addr_o),
    .wrdata_o       (wrdata_o),
    .bwe_o          (bwe_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          slot;
    bit          is_read;
    logic [15:0] addr;
    logic [19:0] data;
    logic [19:0] bwe;
  } event_t;

  event_t      exp_q[$];
  bit          rb_slot[int];
  bit          reset_slot[int];
  int          edge_num = 0;
  int          next_free = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [2:0]  cur_cfg = 3'd5;
  event_t      mon_ev;
  logic [63:0] mon_act;

  always @(posedge clk_i) edge_num++;

  // Lane layout from the port description: 1- and 2-bit lanes live in the first four bits of each 5-bit group.
  function automatic void refLane(input logic [2:0] cfg, input logic [15:0] a,
                                  input logic [19:0] d, input logic [19:0] m,
                                  output logic [19:0] ed, output logic [19:0] em);
    int base, width;
    ed = '0; em = '0; base = 0; width = 0;
    case (cfg)
      3'd1: begin base = 5 * (a[4:1] / 4) + (a[4:1] % 4); width = 1; end
      3'd2: begin base = 5 * (a[4:2] / 2) + 2 * (a[4:2] % 2); width = 2; end
      3'd3: begin base = 5 * a[4:3]; width = 5; end
      3'd4: begin base = 10 * a[4]; width = 10; end
      3'd5, 3'd6, 3'd7: begin ed = d; em = m; end
      default: ;
    endcase
    for (int i = 0; i < width; i++) begin
      ed[base + i] = d[i];
      em[base + i] = m[i];
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_num, act, exp);
    end
  endtask

  // Monitor: outputs after edge N belong to slot N; sampled on the falling edge.
  always @(negedge clk_i) begin
    if (edge_num >= 1) begin
      mon_act = {5'b0, we_o, re_o, busy_o, addr_o, wrdata_o, bwe_o};
      if (reset_slot.exists(edge_num)) checkOutput("reset_outputs", mon_act, 64'd0);
      while (exp_q.size() > 0 && exp_q[0].slot < edge_num) begin
        mon_ev = exp_q.pop_front();
        checkOutput("missed_slot", 64'(edge_num), 64'(mon_ev.slot));
      end
      if (we_o || re_o) begin
        if (exp_q.size() == 0 || exp_q[0].slot != edge_num) begin
          checkOutput("unexpected_strobe", mon_act, 64'd0);
        end else begin
          mon_ev = exp_q.pop_front();
          checkOutput(mon_ev.is_read ? "readback" : "write", mon_act,
                      {5'b0, !mon_ev.is_read, mon_ev.is_read, mon_ev.is_read,
                       mon_ev.addr, mon_ev.data, mon_ev.bwe});
        end
      end else if (exp_q.size() > 0 && exp_q[0].slot == edge_num) begin
        mon_ev = exp_q.pop_front();
        checkOutput("missing_strobe", mon_act,
                    {5'b0, !mon_ev.is_read, mon_ev.is_read, mon_ev.is_read,
                     mon_ev.addr, mon_ev.data, mon_ev.bwe});
      end else if (busy_o) begin
        checkOutput("idle_busy", 64'(busy_o), 64'd0);
      end
    end
  end

  // Drives one cycle and schedules the expected output cycles; a request landing on a readback cycle is withheld.
  task automatic applyStimulus(input bit do_reset, input bit rq, input bit wt, input logic [2:0] cfg,
                               input logic [15:0] a, input logic [19:0] d, input logic [19:0] m,
                               input bit use_exp, input logic [19:0] ed, input logic [19:0] em);
    int c;
    logic [19:0] rd, rm;
    event_t ev;
    @(negedge clk_i);
    c = edge_num + 1;
    if (rb_slot.exists(edge_num)) rq = 1'b0;
    rst_n_i = !do_reset; input_config_i = cfg; we_i = rq; wt_i = wt;
    addr_i = a; wrdata_i = d; bwe_i = m;
    if (do_reset) begin
      reset_slot[c] = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].slot >= c) begin
        ev = exp_q.pop_back();
        if (ev.is_read) rb_slot.delete(ev.slot);
      end
      next_free = c + 1;
    end else if (rq) begin
      refLane(cfg, a, d, m, rd, rm);
      if (use_exp) begin rd = ed; rm = em; end
      ev.slot = (next_free > c) ? next_free : c;
      ev.is_read = 1'b0; ev.addr = a; ev.data = rd; ev.bwe = rm;
      exp_q.push_back(ev);
      if (wt) begin
        ev.slot++; ev.is_read = 1'b1; ev.data = '0; ev.bwe = '0;
        exp_q.push_back(ev);
        rb_slot[ev.slot] = 1'b1;
      end
      next_free = ev.slot + 1;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, cur_cfg, 16'h0, 20'h0, 20'h0, 0, 20'h0, 20'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idleCycles(1);
    idleCycles(1);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [19:0] two_bit_exp [8] = '{20'h00003, 20'h0000C, 20'h00060, 20'h00180,
                                   20'h00C00, 20'h03000, 20'h18000, 20'h60000};
  logic [19:0] rd_a, rd_b;

  initial begin
    rst_n_i = 1'b0; input_config_i = cur_cfg; we_i = 0; wt_i = 0;
    addr_i = '0; wrdata_i = '0; bwe_i = '0;
    reset_slot[1] = 1'b1;
    next_free = 2;
    applyStimulus(1, 0, 0, cur_cfg, 16'h0, 20'h0, 20'h0, 0, 20'h0, 20'h0);

    cur_cfg = 3'd1;
    applyStimulus(0, 1, 0, cur_cfg, 16'h0008, 20'h00001, 20'h00001, 1, 20'h00020, 20'h00020);
    drain();

    cur_cfg = 3'd2;
    for (int k = 0; k < 8; k++) begin
      rd_a = 20'($urandom) | 20'h3;
      applyStimulus(0, 1, 0, cur_cfg, 16'(k << 2), rd_a, 20'hFFFFF, 1,
                    two_bit_exp[k], two_bit_exp[k]);
    end
    drain();

    cur_cfg = 3'd4;
    applyStimulus(0, 1, 0, cur_cfg, 16'h0010, 20'h002AB, 20'h003FF, 1, 20'hAAC00, 20'hFFC00);
    drain();

    cur_cfg = 3'd5;
    rd_a = 20'($urandom); rd_b = 20'($urandom);
    applyStimulus(0, 1, 0, cur_cfg, 16'hBEEF, rd_a, rd_b, 1, rd_a, rd_b);
    applyStimulus(0, 1, 0, cur_cfg, 16'h0042, rd_b, 20'h0, 1, rd_b, 20'h0);
    applyStimulus(0, 1, 1, cur_cfg, 16'h0123, rd_a, rd_b, 1, rd_a, rd_b);
    idleCycles(4);
    applyStimulus(0, 1, 1, cur_cfg, 16'h0321, rd_a, rd_b, 1, rd_a, rd_b);
    applyStimulus(0, 1, 0, cur_cfg, 16'h0456, rd_b, rd_a, 1, rd_b, rd_a);
    drain();

    // Reset during the WRITE cycle must also cancel the readback.
    applyStimulus(0, 1, 1, cur_cfg, 16'h0789, rd_a, rd_b, 1, rd_a, rd_b);
    applyStimulus(1, 1, 0, cur_cfg, 16'h0999, rd_a, rd_b, 0, 20'h0, 20'h0);
    drain();

    cur_cfg = 3'd0;
    applyStimulus(0, 1, 0, cur_cfg, 16'h001E, 20'hFFFFF, 20'hFFFFF, 1, 20'h0, 20'h0);
    drain();

    for (int blk = 0; blk < 8; blk++) begin
      cur_cfg = 3'($urandom_range(0, 7));
      for (int n = 0; n < 150; n++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 2)
          applyStimulus(1, 0, 0, cur_cfg, 16'h0, 20'h0, 20'h0, 0, 20'h0, 20'h0);
        else if (r < 62)
          applyStimulus(0, 1, ($urandom_range(0, 2) == 0), cur_cfg, 16'($urandom),
                        20'($urandom), 20'($urandom), 0, 20'h0, 20'h0);
        else
          idleCycles(1);
      end
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
